// File: rtl/wave_pkg.sv
// Shared types for the DDS output stage: waveform select codes, frame width,
// serial FSM states and the mid-scale attenuation helper.
package wave_pkg;

    localparam int FRAME_W = 16;

    typedef enum logic [1:0] {
        WAVE_SIN = 2'b00,
        WAVE_SAW = 2'b01,
        WAVE_SQU = 2'b10,
        WAVE_TRI = 2'b11
    } wave_sel_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TAIL  = 3'd3,
        HOLD  = 3'd4
    } spi_state_e;

    // Offset-binary sample scaled by 2^-amp about mid-scale (8'h80).
    function automatic logic [7:0] attenuate(input logic [7:0] s, input logic [1:0] amp);
        logic signed [7:0] c_s;
        c_s = signed'({~s[7], s[6:0]});
        c_s = c_s >>> amp;
        return c_s ^ 8'h80;
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// Mode-0 serial frame engine: takes a start request with an 8-bit sample and
// shifts {DAC_CTRL, sample, 4'b0000} out MSB first, then holds cs_n high.
module dac_spi_shifter
    import wave_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [3:0] DAC_CTRL = 4'b0011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       ready,
    output logic       cs_n,
    output logic       sclk,
    output logic       din
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(2 * CLK_DIV - 1);

    spi_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [3:0]         bit_r;
    logic [FRAME_W-1:0] shreg_r;
    logic [FRAME_W-1:0] frame_s;

    assign frame_s = {DAC_CTRL, data, 4'b0000};
    // A new frame may begin from IDLE or straight out of the last HOLD cycle.
    assign ready   = (state_r == IDLE) || ((state_r == HOLD) && (cnt_r == HOLD_LAST));

    // Frame sequencer with SCLK divider, bit counter and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            bit_r   <= 4'd0;
            shreg_r <= '0;
            busy    <= 1'b0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            din     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= LOAD;
                        shreg_r <= frame_s;
                        din     <= frame_s[FRAME_W-1];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    state_r <= SHIFT;
                    cnt_r   <= '0;
                    bit_r   <= 4'd0;
                end
                SHIFT: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Falling edge: present the next bit (zero after the last one).
                            sclk    <= 1'b0;
                            shreg_r <= {shreg_r[FRAME_W-2:0], 1'b0};
                            din     <= shreg_r[FRAME_W-2];
                            bit_r   <= bit_r + 4'd1;
                            if (bit_r == 4'd15) begin
                                state_r <= TAIL;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                TAIL: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r   <= '0;
                        cs_n    <= 1'b1;
                        state_r <= HOLD;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_r <= '0;
                        if (start) begin
                            state_r <= LOAD;
                            shreg_r <= frame_s;
                            din     <= frame_s[FRAME_W-1];
                            cs_n    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy    <= 1'b0;
                    cs_n    <= 1'b1;
                    sclk    <= 1'b0;
                    din     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/wave_dac_driver.sv
// DDS output stage: synchronises the sample clock, selects and attenuates a
// waveform sample, and queues it (one deep) for the serial DAC shifter.
module wave_dac_driver
    import wave_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [3:0] DAC_CTRL = 4'b0011
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       sample_clk,
    input  logic [7:0] data_sin,
    input  logic [7:0] data_saw,
    input  logic [7:0] data_squ,
    input  logic [7:0] data_tri,
    input  logic [1:0] wave_sel,
    input  logic [1:0] amp_sel,
    input  logic       overrun_clr,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic [7:0] sample_out,
    output logic       busy,
    output logic       overrun
);

    logic [1:0] sync_r;
    logic       prev_r;
    logic       tick_s;
    logic [7:0] sel_s;
    logic [7:0] proc_s;
    logic       req_valid_r;
    logic [7:0] req_data_r;
    logic       ready_s;
    logic       consume_s;
    logic       overwrite_s;

    // Sample clock synchroniser and edge history; reset high so a sample_clk
    // already high at reset release does not fake an edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], sample_clk};
            prev_r <= sync_r[1];
        end
    end

    assign tick_s = sync_r[1] & ~prev_r;

    // Waveform select.
    always_comb begin
        sel_s = data_sin;
        case (wave_sel_e'(wave_sel))
            WAVE_SIN: sel_s = data_sin;
            WAVE_SAW: sel_s = data_saw;
            WAVE_SQU: sel_s = data_squ;
            WAVE_TRI: sel_s = data_tri;
            default:  sel_s = data_sin;
        endcase
    end

    assign proc_s      = attenuate(sel_s, amp_sel);
    // The request slot acts as a direct start when the shifter is ready and as
    // the pending buffer while a frame is in flight.
    assign consume_s   = req_valid_r & ready_s;
    assign overwrite_s = tick_s & req_valid_r & ~consume_s;

    // Processed sample, request slot and sticky overrun (set beats clear).
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sample_out  <= 8'h80;
            req_valid_r <= 1'b0;
            req_data_r  <= 8'h00;
            overrun     <= 1'b0;
        end else begin
            if (tick_s) begin
                sample_out  <= proc_s;
                req_data_r  <= proc_s;
                req_valid_r <= 1'b1;
            end else if (consume_s) begin
                req_valid_r <= 1'b0;
            end
            if (overwrite_s) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    dac_spi_shifter #(
        .CLK_DIV  (CLK_DIV),
        .DAC_CTRL (DAC_CTRL)
    ) u_shifter (
        .clk   (sys_clk),
        .rst   (rst),
        .start (req_valid_r),
        .data  (req_data_r),
        .busy  (busy),
        .ready (ready_s),
        .cs_n  (dac_cs_n),
        .sclk  (dac_sclk),
        .din   (dac_din)
    );

endmodule

// File: tb/tb_wave_dac_driver.sv
// Self-checking bench for wave_dac_driver: vector table, directed corner
// sequences and randomized samples against an arithmetic reference model.
module tb_wave_dac_driver;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       sample_clk;
    logic [7:0] data_sin, data_saw, data_squ, data_tri;
    logic [1:0] wave_sel, amp_sel;
    logic       overrun_clr;
    logic       dac_cs_n, dac_sclk, dac_din;
    logic [7:0] sample_out;
    logic       busy, overrun;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    wave_dac_driver #(.CLK_DIV(4), .DAC_CTRL(4'b0011)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .sample_clk  (sample_clk),
        .data_sin    (data_sin),
        .data_saw    (data_saw),
        .data_squ    (data_squ),
        .data_tri    (data_tri),
        .wave_sel    (wave_sel),
        .amp_sel     (amp_sel),
        .overrun_clr (overrun_clr),
        .dac_cs_n    (dac_cs_n),
        .dac_sclk    (dac_sclk),
        .dac_din     (dac_din),
        .sample_out  (sample_out),
        .busy        (busy),
        .overrun     (overrun)
    );

    typedef struct {
        logic [15:0] word;
        int          nbits;
        int          cs_low;
    } frame_t;

    typedef struct {
        logic [1:0] wave;
        logic [1:0] amp;
        logic [7:0] d_sin;
        logic [7:0] d_saw;
        logic [7:0] d_squ;
        logic [7:0] d_tri;
        logic [7:0] exp_out;
    } vec_t;

    frame_t      frames[$];
    int          busy_lens[$];
    logic [15:0] mon_word;
    int          mon_bits, mon_low, mon_busy;
    logic        prev_sclk, prev_cs_n, prev_busy;

    // DAC-side receiver: captures din on each sclk rise while cs_n is low.
    always @(negedge sys_clk) begin
        if (rst) begin
            mon_word = 16'h0000; mon_bits = 0; mon_low = 0; mon_busy = 0;
            prev_sclk = 1'b0; prev_cs_n = 1'b1; prev_busy = 1'b0;
        end else begin
            if (!dac_cs_n) mon_low++;
            if (dac_sclk && !prev_sclk && !dac_cs_n) begin
                mon_word = {mon_word[14:0], dac_din};
                mon_bits++;
            end
            if (dac_cs_n && !prev_cs_n) begin
                frames.push_back('{mon_word, mon_bits, mon_low});
                mon_word = 16'h0000; mon_bits = 0; mon_low = 0;
            end
            if (busy) mon_busy++;
            if (!busy && prev_busy) begin
                busy_lens.push_back(mon_busy);
                mon_busy = 0;
            end
            prev_sclk = dac_sclk; prev_cs_n = dac_cs_n; prev_busy = busy;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] exp_byte);
        frame_t f;
        if (frames.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: no frame captured, expected %0h", name, {4'b0011, exp_byte, 4'b0000});
        end else begin
            f = frames.pop_front();
            check(name, 32'(f.word), 32'({4'b0011, exp_byte, 4'b0000}));
            check({name, "_bits"}, 32'(f.nbits), 32'd16);
        end
    endtask

    // Reference: floor((s - 128) / 2^amp) + 128.
    function automatic logic [7:0] ref_att(input logic [7:0] s, input int amp);
        int v, d, q;
        v = int'(s) - 128;
        d = 1 << amp;
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        return 8'(q + 128);
    endfunction

    task automatic apply(input logic [1:0] w, input logic [1:0] a, input logic [7:0] s0,
                         input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
        wave_sel = w; amp_sel = a;
        data_sin = s0; data_saw = s1; data_squ = s2; data_tri = s3;
    endtask

    // One sample_clk pulse; the tick registers at the third edge after the rise,
    // and overrun_clr (if requested) is high for exactly that edge.
    task automatic tick_sync(input logic with_clr);
        @(posedge sys_clk); #3 sample_clk = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk); #1 overrun_clr = with_clr;
        @(posedge sys_clk); #1 overrun_clr = 1'b0;
        sample_clk = 1'b0;
        repeat (3) @(posedge sys_clk);
    endtask

    task automatic wait_quiet(input string name);
        int idle = 0;
        int n = 0;
        while (idle < 30 && n < 2000) begin
            @(negedge sys_clk);
            n++;
            if (busy) idle = 0;
            else      idle++;
        end
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL %s: busy never dropped within %0d cycles", name, n);
        end
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{2'd1, 2'd0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[1]  = '{2'd1, 2'd1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hBF};
        vecs[2]  = '{2'd1, 2'd2, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h9F};
        vecs[3]  = '{2'd1, 2'd3, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h8F};
        vecs[4]  = '{2'd1, 2'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[5]  = '{2'd1, 2'd1, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h40};
        vecs[6]  = '{2'd1, 2'd2, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h60};
        vecs[7]  = '{2'd1, 2'd3, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h70};
        vecs[8]  = '{2'd0, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        vecs[9]  = '{2'd1, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22};
        vecs[10] = '{2'd2, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33};
        vecs[11] = '{2'd3, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        vecs[12] = '{2'd2, 2'd3, 8'h11, 8'h22, 8'h80, 8'h44, 8'h80};

        rst = 1'b1; sample_clk = 1'b0; overrun_clr = 1'b0;
        apply(2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_cs_n", 32'(dac_cs_n), 32'd1);
        check("rst_sclk", 32'(dac_sclk), 32'd0);
        check("rst_din", 32'(dac_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_sample_out", 32'(sample_out), 32'h80);
        #1 rst = 1'b0;
        repeat (5) @(posedge sys_clk);

        // Single frame with latency checks.
        apply(2'd0, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00);
        frames.delete(); busy_lens.delete();
        @(posedge sys_clk); #3 sample_clk = 1'b1;
        @(posedge sys_clk);
        @(posedge sys_clk); #1 check("pre_tick_out", 32'(sample_out), 32'h80);
        @(posedge sys_clk); #1 check("tick_out", 32'(sample_out), 32'hA5);
        check("cs_before_load", 32'(dac_cs_n), 32'd1);
        @(posedge sys_clk); #1 check("cs_fall", 32'(dac_cs_n), 32'd0);
        check("busy_load", 32'(busy), 32'd1);
        sample_clk = 1'b0;
        wait_quiet("single");
        if (frames.size() > 0) check("cs_low_len", 32'(frames[0].cs_low), 32'd133);
        check_frame("single_frame", 8'hA5);
        check("busy_len_count", 32'(busy_lens.size()), 32'd1);
        if (busy_lens.size() > 0) check("busy_len", 32'(busy_lens[0]), 32'd141);

        // Vector table: attenuation and selector sweep.
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].wave, vecs[i].amp, vecs[i].d_sin, vecs[i].d_saw, vecs[i].d_squ, vecs[i].d_tri);
            frames.delete();
            tick_sync(1'b0);
            wait_quiet("vec");
            check($sformatf("vec%0d_out", i), 32'(sample_out), 32'(vecs[i].exp_out));
            check_frame($sformatf("vec%0d_frame", i), vecs[i].exp_out);
        end

        // Mid-frame input change must not alter the frame in flight.
        apply(2'd0, 2'd0, 8'h5C, 8'h00, 8'h00, 8'h00);
        frames.delete();
        tick_sync(1'b0);
        repeat (40) @(posedge sys_clk);
        #1 apply(2'd3, 2'd2, 8'h00, 8'h12, 8'h34, 8'hEE);
        wait_quiet("midchg");
        check_frame("midchg_frame", 8'h5C);
        check("midchg_out", 32'(sample_out), 32'h5C);

        // Three ticks in one frame: second frame carries the third sample.
        apply(2'd0, 2'd0, 8'h21, 8'h00, 8'h00, 8'h00);
        frames.delete();
        tick_sync(1'b0);
        repeat (20) @(posedge sys_clk);
        data_sin = 8'h42;
        tick_sync(1'b0);
        check("ovr_after_pending", 32'(overrun), 32'd0);
        repeat (20) @(posedge sys_clk);
        data_sin = 8'h63;
        tick_sync(1'b0);
        check("ovr_set", 32'(overrun), 32'd1);
        wait_quiet("ovr");
        check("ovr_frame_count", 32'(frames.size()), 32'd2);
        check_frame("ovr_frame1", 8'h21);
        check_frame("ovr_frame2", 8'h63);
        @(posedge sys_clk); #1 overrun_clr = 1'b1;
        @(posedge sys_clk); #1 overrun_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Clear in the same cycle as an overwrite: set wins.
        data_sin = 8'h71;
        frames.delete();
        tick_sync(1'b0);
        repeat (20) @(posedge sys_clk);
        data_sin = 8'h72;
        tick_sync(1'b0);
        repeat (20) @(posedge sys_clk);
        data_sin = 8'h73;
        tick_sync(1'b1);
        check("ovr_set_beats_clr", 32'(overrun), 32'd1);
        wait_quiet("ovr2");
        check_frame("ovr2_frame1", 8'h71);
        check_frame("ovr2_frame2", 8'h73);
        @(posedge sys_clk); #1 overrun_clr = 1'b1;
        @(posedge sys_clk); #1 overrun_clr = 1'b0;
        check("ovr2_cleared", 32'(overrun), 32'd0);

        // Tick landing in the last HOLD cycle starts directly, no overrun.
        data_sin = 8'h0A;
        frames.delete();
        tick_sync(1'b0);
        repeat (135) @(posedge sys_clk);
        data_sin = 8'h0B;
        tick_sync(1'b0);
        wait_quiet("holdend");
        check("holdend_overrun", 32'(overrun), 32'd0);
        check("holdend_frames", 32'(frames.size()), 32'd2);
        check_frame("holdend_frame1", 8'h0A);
        check_frame("holdend_frame2", 8'h0B);

        // Reset during SHIFT bit 7.
        data_sin = 8'h99;
        frames.delete();
        tick_sync(1'b0);
        begin
            int n = 0;
            while (mon_bits != 7 && n < 500) begin
                @(negedge sys_clk); #1;
                n++;
            end
            check("bit7_reached", 32'(mon_bits), 32'd7);
        end
        #1 rst = 1'b1;
        #1;
        check("midrst_cs_n", 32'(dac_cs_n), 32'd1);
        check("midrst_sclk", 32'(dac_sclk), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out", 32'(sample_out), 32'h80);
        #20 rst = 1'b0;
        frames.delete();
        repeat (300) @(posedge sys_clk);
        #1;
        check("midrst_no_frame", 32'(frames.size()), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        data_sin = 8'h3C;
        tick_sync(1'b0);
        wait_quiet("postrst");
        check_frame("postrst_frame", 8'h3C);

        // Randomized samples against the reference model.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d[4];
            logic [1:0] w, a;
            logic [7:0] exp_v;
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
            w = 2'($urandom_range(0, 3));
            a = 2'($urandom_range(0, 3));
            exp_v = ref_att(d[w], int'(a));
            apply(w, a, d[0], d[1], d[2], d[3]);
            frames.delete();
            tick_sync(1'b0);
            repeat ($urandom_range(1, 100)) @(posedge sys_clk);
            #1 apply(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_quiet("rand");
            check($sformatf("rand%0d_out", i), 32'(sample_out), 32'(exp_v));
            check_frame($sformatf("rand%0d_frame", i), exp_v);
        end
        check("final_overrun", 32'(overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_dac_driver.md
# wave_dac_driver

- Downstream output stage of the DDS waveform generator.
- Takes the four 8-bit ROM sample streams (sine, sawtooth, square, triangle), selects one, applies a power-of-two amplitude attenuation about mid-scale, and ships each new sample to an external 8-bit serial DAC as a 16-bit SPI-style frame.
- Runs entirely in the 100 MHz domain. Treats the 10 kHz sample clock as an asynchronous data input.

## Interface
Parameters:
- CLK_DIV, 4, sys_clk cycles per SCLK half-period; legal range ≥2.
- DAC_CTRL, 4'b0011, control nibble sent in frame bits [15:12].

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- sys_clk  in  1  100 MHz clock; all logic is clocked on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_clk  in  1  10 kHz sample clock; asynchronous to sys_clk.
- data_sin, data_saw, data_squ, data_tri  in  8 each  offset-binary ROM samples.
- wave_sel  in  2  waveform select: 00 sin, 01 saw, 10 squ, 11 tri.
- amp_sel  in  2  attenuation shift, 0..3.
- overrun_clr  in  1  single-cycle pulse that clears the overrun flag.
- dac_cs_n  out  1  DAC chip select, active low.
- dac_sclk  out  1  DAC serial clock; idles low.
- dac_din  out  1  DAC serial data, MSB first.
- sample_out  out  8  last processed sample (monitor output).
- busy  out  1  high while a frame is in flight.
- overrun  out  1  sticky flag: a pending sample was overwritten.

## Operation
- **Tick generation:** sample_clk passes through a 2-FF synchroniser and then a rising-edge detector, producing a one-cycle tick.
- **Sample processing on tick:**
  - Select the input sample by wave_sel.
  - Convert to signed: c = {~s[7], s[6:0]}.
  - Arithmetic shift: c >>> amp_sel.
  - Convert back to offset binary by XOR 8'h80.
  - Register the result into sample_out.
  - Examples: amp_sel=1, 8'hFF → 8'hBF; 8'h00 → 8'h40; 8'h80 → 8'h80 at any amp_sel.
- **Frame format:** {DAC_CTRL, sample_out, 4'b0000}, 16 bits, MSB first.
- **FSM states:**
  - IDLE: leave when a sample is available → LOAD.
  - LOAD: one cycle; cs_n goes low, din = bit15.
  - SHIFT: 16 SCLK periods.
  - TAIL: CLK_DIV cycles with sclk low, then cs_n goes high.
  - HOLD: 2·CLK_DIV cycles with cs_n high; then → LOAD if a sample is pending, else → IDLE.
- **SPI mode 0:** din changes on the sclk falling edge (the first bit at LOAD); the DAC samples on the rising edge.
- **Pending buffer (1-deep):**
  - A tick while busy stores the processed sample as pending.
  - A tick while pending is already full overwrites pending and sets overrun.
- **overrun clear:** overrun clears on overrun_clr. If a set and a clear occur in the same cycle, the set wins.
- **Input sampling:** wave_sel and amp_sel are sampled only at the tick; changing them mid-frame does not affect the current frame.

## Timing
- **Reset values:** dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, overrun=0, sample_out=8'h80. The pending buffer is empty and the FSM is in IDLE.
- **Sample-path latency:**
  - Tick asserts 3 sys_clk cycles after the sample_clk rising edge (±1 cycle of synchroniser uncertainty).
  - sample_out updates 1 cycle after the tick.
  - dac_cs_n falls 1 cycle after sample_out updates.
- **Frame length:** 1 + 32·CLK_DIV + CLK_DIV + 2·CLK_DIV cycles; 141 cycles (1.41 µs) at CLK_DIV=4.
- **busy:** high from LOAD through the end of HOLD.
- **Reset mid-frame:** outputs return immediately (asynchronously) to their reset values. The frame is abandoned and the pending sample is dropped.
- **Tick in the HOLD cycle:** a tick arriving in the same cycle that HOLD ends is treated as a direct start, with no pending stored and no overrun.

## Structure
- **Package wave_pkg:** wave_sel encodings, FRAME_W=16, and the FSM state enum (IDLE, LOAD, SHIFT, TAIL, HOLD).
- **Sub-module dac_spi_shifter:** contains the FSM, the SCLK divider, the bit counter and the shift register; uses a start/data-in/busy handshake.
- **Top level:** synchroniser, edge detect, mux/attenuate, and the pending buffer.

## Test plan
- **Reset and single frame:** reset, then one sample_clk edge with wave_sel=00, data_sin=8'hA5, amp_sel=0.
  - Required: cs_n low for one frame; sixteen rising sclk edges capture 16'h3A50; busy drops after 141 cycles.
- **Attenuation:** amp_sel=0..3 with data_saw=8'hFF.
  - Required: sample_out = FF, BF, 9F, 8F.
- **Attenuation of zero:** data_saw=8'h00.
  - Required: sample_out = 00, 40, 60, 70.
- **Overrun:** three ticks within one frame (force sample_clk fast).
  - Required: the second frame carries the third sample and overrun=1.
  - overrun_clr asserted in the same cycle as a new overwrite leaves overrun=1.
- **Reset mid-frame:** assert rst during SHIFT bit 7.
  - Required: cs_n=1 and sclk=0 immediately; no frame follows deassertion until the next tick.
- **Selector sweep:** wave_sel 00..11 with distinct inputs (11, 22, 33, 44) at amp_sel=0.
  - Required: frames carry 11, 22, 33, 44 in order.
  - A mid-frame wave_sel change does not corrupt the frame in flight.
